// File: rtl/tmds_decoder.sv
// TMDS channel decoder: hunts for symbol alignment using runs of control
// tokens, then decodes each 10-bit symbol into pixel data, control and DE.
module tmds_decoder #(
    parameter int unsigned CTRL_RUN       = 8,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned LOCK_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] raw_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] slip
);

    localparam int unsigned TmoMax = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT
                                                                      : LOCK_TIMEOUT;
    localparam int unsigned TmoW = (TmoMax > 1) ? $clog2(TmoMax) : 1;
    localparam int unsigned RunW = $clog2(CTRL_RUN + 1);

    localparam logic [TmoW-1:0] SearchLast = TmoW'(SEARCH_TIMEOUT - 1);
    localparam logic [TmoW-1:0] LockLast   = TmoW'(LOCK_TIMEOUT - 1);
    localparam logic [RunW-1:0] RunFull    = RunW'(CTRL_RUN);

    typedef enum logic [1:0] {StSearch, StSettle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [3:0]      slip_q, slip_d, slip_inc;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [RunW-1:0] run_q, run_d, run_inc;
    logic            settle_q, settle_d;

    logic [9:0]  raw_prev_q, sym_q, aligned;
    logic [19:0] win_sh;

    logic       is_tok;
    logic [1:0] tok_val;
    logic [7:0] dec_d, dec;

    logic [7:0] data_q, data_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       de_q, de_d, locked_q;

    // Bit 0 of the window is the earliest received bit, so slip selects the start offset.
    assign win_sh  = {raw_in, raw_prev_q} >> slip_q;
    assign aligned = win_sh[9:0];

    assign slip_inc = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;

    // Token match and TMDS data decode of the aligned symbol.
    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        unique case (sym_q)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
        dec_d  = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        dec    = '0;
        dec[0] = dec_d[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym_q[8] ? (dec_d[i] ^ dec_d[i-1]) : ~(dec_d[i] ^ dec_d[i-1]);
        end
    end

    // Alignment FSM, run counter and timeout counter next-state.
    always_comb begin
        run_inc  = is_tok ? ((run_q == RunFull) ? run_q : run_q + RunW'(1)) : '0;
        state_d  = state_q;
        slip_d   = slip_q;
        tmo_d    = tmo_q;
        run_d    = run_inc;
        settle_d = settle_q;
        unique case (state_q)
            StSearch: begin
                tmo_d = tmo_q + TmoW'(1);
                if (run_inc == RunFull) begin
                    state_d = StLocked;
                    tmo_d   = '0;
                end else if (tmo_q == SearchLast) begin
                    state_d  = StSettle;
                    slip_d   = slip_inc;
                    run_d    = '0;
                    tmo_d    = '0;
                    settle_d = 1'b0;
                end
            end
            StSettle: begin
                // Two cycles: sym_q still holds a symbol cut at the old offset.
                run_d    = '0;
                tmo_d    = '0;
                settle_d = 1'b1;
                if (settle_q) begin
                    state_d  = StSearch;
                    settle_d = 1'b0;
                end
            end
            StLocked: begin
                if (run_q == RunFull) begin
                    tmo_d = '0;
                end else if (tmo_q == LockLast) begin
                    state_d  = StSettle;
                    slip_d   = slip_inc;
                    run_d    = '0;
                    tmo_d    = '0;
                    settle_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: begin
                state_d  = StSearch;
                run_d    = '0;
                tmo_d    = '0;
                settle_d = 1'b0;
            end
        endcase
    end

    // Output stage next values; everything is gated off unless aligned.
    always_comb begin
        de_d   = 1'b0;
        data_d = 8'h00;
        ctrl_d = 2'b00;
        if (state_q == StLocked) begin
            if (is_tok) begin
                ctrl_d = tok_val;
            end else begin
                de_d   = 1'b1;
                data_d = dec;
                ctrl_d = ctrl_q;
            end
        end
    end

    // Input history, stage 1 symbol register and FSM state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_prev_q <= '0;
            sym_q      <= '0;
            state_q    <= StSearch;
            slip_q     <= '0;
            tmo_q      <= '0;
            run_q      <= '0;
            settle_q   <= 1'b0;
        end else begin
            raw_prev_q <= raw_in;
            sym_q      <= aligned;
            state_q    <= state_d;
            slip_q     <= slip_d;
            tmo_q      <= tmo_d;
            run_q      <= run_d;
            settle_q   <= settle_d;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            ctrl_q   <= '0;
            de_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            de_q     <= de_d;
            locked_q <= (state_q == StLocked);
        end
    end

    assign data   = data_q;
    assign ctrl   = ctrl_q;
    assign de     = de_q;
    assign locked = locked_q;
    assign slip   = slip_q;

endmodule
